// File: rtl/amt_recovery_ctrl_pkg.sv
// Shared definitions for the architectural-to-speculative map recovery path.
// Holds the map-table geometry, the recovery sequencer state encoding and
// the {logical index, physical tag} packet exchanged between the
// ArchMapTable read side and the Rename Map Table write side.
package amt_pkg;

  localparam int NUM_LOG_REGS = 34;  // RMT/AMT entries
  localparam int LOG_W        = 6;   // logical-register index width
  localparam int PHYS_W       = 7;   // physical-register tag width
  localparam int COMMIT_WIDTH = 4;   // RMT write ports / copy group size

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    COPY  = 2'd2,
    DONE  = 2'd3
  } rec_state_e;

  typedef struct packed {
    logic [LOG_W-1:0]  log_idx;
    logic [PHYS_W-1:0] phys_tag;
  } map_pkt_t;

endpackage

// File: rtl/amt_recovery_ctrl_if.sv
// Bundle between the recovery sequencer and its neighbours: ActiveList
// (request / commit-in-flight / commit stall), ArchMapTable read ports and
// Rename Map Table write ports, one lane per commit slot.
//   master : the recovery controller (drives addresses, write enables, packets,
//            stall/busy/done; receives request, in-flight, read data, ready)
//   slave  : the surrounding pipeline / map tables
interface amt_recovery_ctrl_if #(
  parameter int LOG_W  = amt_pkg::LOG_W,
  parameter int PHYS_W = amt_pkg::PHYS_W,
  parameter int LANES  = amt_pkg::COMMIT_WIDTH
);
  import amt_pkg::*;

  logic                                recoverReq_i;
  logic                                commitInFlight_i;
  logic                                commitStall_o;
  logic [LANES-1:0][LOG_W-1:0]         amtRdAddr_o;
  logic [LANES-1:0][PHYS_W-1:0]        amtRdData_i;
  logic                                rmtReady_i;
  logic [LANES-1:0]                    rmtWe_o;
  logic [LANES-1:0][LOG_W+PHYS_W-1:0]  rmtPacket_o;
  logic                                recoverBusy_o;
  logic                                recoverDone_o;

  modport master (
    input  recoverReq_i, commitInFlight_i, amtRdData_i, rmtReady_i,
    output commitStall_o, amtRdAddr_o, rmtWe_o, rmtPacket_o,
           recoverBusy_o, recoverDone_o
  );

  modport slave (
    output recoverReq_i, commitInFlight_i, amtRdData_i, rmtReady_i,
    input  commitStall_o, amtRdAddr_o, rmtWe_o, rmtPacket_o,
           recoverBusy_o, recoverDone_o
  );

endinterface

// File: rtl/amt_recovery_ctrl.sv
// Recovery sequencer: after an exception or mispredict it stalls commit,
// waits for in-flight AMT writes to land, then copies every AMT entry into
// the RMT in groups of COMMIT_WIDTH, honouring RMT backpressure.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - amt_recovery_ctrl_if.master: recoverReq_i, commitInFlight_i,
//           commitStall_o, amtRdAddr_o[k], amtRdData_i[k], rmtReady_i,
//           rmtWe_o[k], rmtPacket_o[k], recoverBusy_o, recoverDone_o
module amt_recovery_ctrl #(
  parameter int NUM_LOG_REGS = amt_pkg::NUM_LOG_REGS,
  parameter int LOG_W        = amt_pkg::LOG_W,
  parameter int PHYS_W       = amt_pkg::PHYS_W
) (
  input  logic                clk,
  input  logic                reset,
  amt_recovery_ctrl_if.master bus
);
  import amt_pkg::*;

  // One extra bit so cnt+k and cnt+GROUP never wrap near the table end.
  localparam logic [LOG_W:0] NREGS = (LOG_W+1)'(NUM_LOG_REGS);
  localparam logic [LOG_W:0] GROUP = (LOG_W+1)'(COMMIT_WIDTH);

  rec_state_e     state_q, state_d;
  logic [LOG_W:0] cnt_q, cnt_d;
  logic [LOG_W:0] cnt_next;
  logic           in_copy;

  assign cnt_next = cnt_q + GROUP;
  assign in_copy  = (state_q == COPY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new request in any busy state restarts the whole pass from DRAIN so
  // the aborted pass never reports completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.recoverReq_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (bus.recoverReq_i) begin
          cnt_d = '0;
        end else if (!bus.commitInFlight_i) begin
          state_d = COPY;
        end
      end
      COPY: begin
        if (bus.recoverReq_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else if (bus.rmtReady_i) begin
          cnt_d = cnt_next;
          if (cnt_next >= NREGS) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.recoverReq_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.commitStall_o = (state_q != IDLE);
  assign bus.recoverBusy_o = (state_q != IDLE);
  assign bus.recoverDone_o = (state_q == DONE);

  // Per-lane read address / write enable / packet. Lanes past the last
  // logical register stay silent, which yields the partial final group.
  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
    logic [LOG_W:0] idx;
    logic           lane_ok;

    assign idx     = cnt_q + (LOG_W+1)'(k);
    assign lane_ok = in_copy && (idx < NREGS);

    assign bus.amtRdAddr_o[k] = lane_ok ? idx[LOG_W-1:0] : '0;
    assign bus.rmtWe_o[k]     = lane_ok && bus.rmtReady_i;
    assign bus.rmtPacket_o[k] = bus.rmtWe_o[k] ? {bus.amtRdAddr_o[k], bus.amtRdData_i[k]}
                                               : '0;
  end

endmodule

// File: tb/tb_amt_recovery_ctrl.sv
module tb_amt_recovery_ctrl;
  import amt_pkg::*;

  localparam int          NG        = 9;        // ceil(34/4) groups
  localparam logic [3:0]  LAST_MASK = 4'b0011;  // 34 = 8*4 + 2

  typedef struct {
    logic       rst;
    logic       req;
    logic       infl;
    logic       rdy;
    logic       amt5;
    logic       busy;
    logic       done;
    logic [3:0] we;
    logic [5:0] addr0;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  amt_recovery_ctrl_if #(.LOG_W(LOG_W), .PHYS_W(PHYS_W), .LANES(COMMIT_WIDTH)) if34 ();
  amt_recovery_ctrl_if #(.LOG_W(LOG_W), .PHYS_W(PHYS_W), .LANES(COMMIT_WIDTH)) if32 ();

  amt_recovery_ctrl #(.NUM_LOG_REGS(34), .LOG_W(LOG_W), .PHYS_W(PHYS_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (if34)
  );

  amt_recovery_ctrl #(.NUM_LOG_REGS(32), .LOG_W(LOG_W), .PHYS_W(PHYS_W)) dut32 (
    .clk  (clk),
    .reset(reset),
    .bus  (if32)
  );

  logic [PHYS_W-1:0] amt [64];
  logic [PHYS_W-1:0] rmt [64];
  int                wcnt [64];

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if34.amtRdData_i[k] = amt[if34.amtRdAddr_o[k]];
      if32.amtRdData_i[k] = PHYS_W'(if32.amtRdAddr_o[k]) + 7'd40;
    end
  end

  int       total = 0;
  int       bad   = 0;
  vec_t     vq[$];
  map_pkt_t sbq[$];
  logic     mon_en = 1'b0;
  int       wtotal, done34, wr32, groups32, partial32, exp32, lat, errs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic req, input logic infl, input logic rdy,
                     input logic amt5, input logic busy, input logic done,
                     input logic [3:0] we, input int addr0);
    vec_t v;
    v.rst = rst; v.req = req; v.infl = infl; v.rdy = rdy; v.amt5 = amt5;
    v.busy = busy; v.done = done; v.we = we; v.addr0 = 6'(addr0);
    vq.push_back(v);
  endtask

  task automatic add_copy_full();
    for (int g = 0; g < NG; g++)
      add(0, 0, 0, 1, 0, 1, 0, (g == NG-1) ? LAST_MASK : 4'hF, g*4);
  endtask

  task automatic push_range(input int lo, input int hi);
    map_pkt_t e;
    for (int i = lo; i <= hi; i++) begin
      e.log_idx  = 6'(i);
      e.phys_tag = 7'(i + 40);
      sbq.push_back(e);
    end
  endtask

  task automatic run_vecs();
    vec_t v;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk); #1;
      reset                 = v.rst;
      if34.recoverReq_i     = v.req;
      if34.commitInFlight_i = v.infl;
      if34.rmtReady_i       = v.rdy;
      if (v.amt5) amt[5] = 7'd99;
      @(negedge clk);
      check($sformatf("busy[%0d]", i),  32'(if34.recoverBusy_o), 32'(v.busy));
      check($sformatf("stall[%0d]", i), 32'(if34.commitStall_o), 32'(v.busy));
      check($sformatf("done[%0d]", i),  32'(if34.recoverDone_o), 32'(v.done));
      check($sformatf("we[%0d]", i),    32'(if34.rmtWe_o),       32'(v.we));
      check($sformatf("addr0[%0d]", i), 32'(if34.amtRdAddr_o[0]), 32'(v.addr0));
      if (!v.busy)
        check($sformatf("addr_hi[%0d]", i),
              32'({if34.amtRdAddr_o[3], if34.amtRdAddr_o[2], if34.amtRdAddr_o[1]}), 32'(0));
    end
    vq.delete();
  endtask

  task automatic check_rmt(input string name);
    errs = 0;
    for (int i = 0; i < 34; i++)
      if (rmt[i] !== ((i == 5 && name == "rmt_after_inflight") ? 7'd99 : 7'(i + 40))) errs++;
    check(name, 32'(errs), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    map_pkt_t a, e;
    reset = 1'b1;
    if34.recoverReq_i = 0; if34.commitInFlight_i = 0; if34.rmtReady_i = 0;
    if32.recoverReq_i = 0; if32.commitInFlight_i = 0; if32.rmtReady_i = 1;
    for (int i = 0; i < 64; i++) begin
      amt[i] = 7'(i + 40); rmt[i] = '0; wcnt[i] = 0;
    end
    wtotal = 0; done34 = 0; wr32 = 0; groups32 = 0; partial32 = 0; exp32 = 0;

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (if34.recoverDone_o) done34++;
          for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (if34.rmtWe_o[k]) begin
              a = if34.rmtPacket_o[k];
              if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: lane %0d packet %0h, required no write", k, a);
              end else begin
                e = sbq.pop_front();
                check($sformatf("packet_lane%0d", k), 32'(a), 32'(e));
              end
              rmt[a.log_idx] = a.phys_tag;
              wcnt[a.log_idx]++;
              wtotal++;
            end else begin
              check($sformatf("idle_packet_lane%0d", k), 32'(if34.rmtPacket_o[k]), 32'(0));
            end
          end
          if (if32.rmtWe_o != 4'h0) begin
            groups32++;
            if (if32.rmtWe_o != 4'hF) partial32++;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
              if (if32.rmtWe_o[k]) begin
                check("packet32", 32'(if32.rmtPacket_o[k]), 32'({6'(exp32), 7'(exp32 + 40)}));
                exp32++;
                wr32++;
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    // Reset state, then the basic 34-entry copy: request at row 5.
    push_range(0, 33);
    add(1, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    add_copy_full();
    add(0, 0, 0, 1, 0, 1, 1, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    done34 = 0;
    run_vecs();
    check("sb_empty_basic", 32'(sbq.size()), 32'(0));
    check("done_count_basic", 32'(done34), 32'(1));
    check_rmt("rmt_after_basic");

    // Commit in flight for 3 cycles; AMT[5] updated during drain.
    push_range(0, 33);
    sbq[5].phys_tag = 7'd99;
    add(0, 1, 1, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 1, 1, 1, 1, 0, 4'h0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    add_copy_full();
    add(0, 0, 0, 1, 0, 1, 1, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    run_vecs();
    check("sb_empty_inflight", 32'(sbq.size()), 32'(0));
    check_rmt("rmt_after_inflight");
    amt[5] = 7'd45;

    // Backpressure: ready 1,0,0,1,...
    for (int i = 0; i < 64; i++) wcnt[i] = 0;
    wtotal = 0;
    push_range(0, 33);
    add(0, 1, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    for (int g = 0; g < NG; g++) begin
      add(0, 0, 0, 1, 0, 1, 0, (g == NG-1) ? LAST_MASK : 4'hF, g*4);
      if (g < NG-1) begin
        add(0, 0, 0, 0, 0, 1, 0, 4'h0, (g+1)*4);
        add(0, 0, 0, 0, 0, 1, 0, 4'h0, (g+1)*4);
      end
    end
    add(0, 0, 0, 1, 0, 1, 1, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    run_vecs();
    check("writes_backpressure", 32'(wtotal), 32'(34));
    errs = 0;
    for (int i = 0; i < 34; i++) if (wcnt[i] != 1) errs++;
    check("no_duplicates", 32'(errs), 32'(0));
    check("sb_empty_backpressure", 32'(sbq.size()), 32'(0));
    check_rmt("rmt_after_backpressure");

    // Restart request while copying the group at cnt=12.
    push_range(0, 15);
    push_range(0, 33);
    add(0, 1, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'hF, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'hF, 4);
    add(0, 0, 0, 1, 0, 1, 0, 4'hF, 8);
    add(0, 1, 0, 1, 0, 1, 0, 4'hF, 12);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    add_copy_full();
    add(0, 0, 0, 1, 0, 1, 1, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    done34 = 0;
    run_vecs();
    check("done_count_restart", 32'(done34), 32'(1));
    check("sb_empty_restart", 32'(sbq.size()), 32'(0));

    // Reset in the middle of COPY, then a full copy.
    push_range(0, 7);
    add(0, 1, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'hF, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'hF, 4);
    add(1, 0, 0, 0, 0, 1, 0, 4'h0, 8);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    run_vecs();
    check("sb_empty_reset", 32'(sbq.size()), 32'(0));
    for (int i = 0; i < 64; i++) rmt[i] = '0;
    push_range(0, 33);
    add(0, 1, 0, 1, 0, 0, 0, 4'h0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 4'h0, 0);
    add_copy_full();
    add(0, 0, 0, 1, 0, 1, 1, 4'h0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h0, 0);
    run_vecs();
    check("sb_empty_after_reset_copy", 32'(sbq.size()), 32'(0));
    check_rmt("rmt_after_reset_copy");

    // 32-entry build: 8 full groups, done 10 cycles after the request.
    wr32 = 0; groups32 = 0; partial32 = 0; exp32 = 0; lat = -1;
    @(posedge clk); #1 if32.recoverReq_i = 1'b1;
    @(posedge clk); #1 if32.recoverReq_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if32.recoverDone_o) begin
        lat = c;
        break;
      end
    end
    check("latency32", 32'(lat), 32'(10));
    check("writes32", 32'(wr32), 32'(32));
    check("groups32", 32'(groups32), 32'(8));
    check("partial32", 32'(partial32), 32'(0));
    @(negedge clk);
    check("idle32", 32'(if32.recoverBusy_o), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amt_recovery_ctrl.md
Name: amt_recovery_ctrl

Overview:
- Sequences the architectural-to-speculative map copy after an exception or branch mispredict.
- On a recovery request it stalls commit and waits for in-flight AMT writes to land.
- It then walks every logical register in groups of 4, reading the Architectural Map Table and writing the Rename Map Table through its 4 write ports, with RMT backpressure.
- Sits between ActiveList, ArchMapTable read ports and RMT write ports; replaces the free-running recover counter.

Parameters:
NUM_LOG_REGS, 34, number of logical registers (RMT/AMT entries); any value >= 4.
LOG_W, 6, width of logical-register index; must satisfy 2**LOG_W >= NUM_LOG_REGS.
PHYS_W, 7, width of physical-register tag.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
recoverReq_i  in  1  one-cycle pulse from ActiveList: exception/mispredict recovery required
commitInFlight_i  in  1  ActiveList has AMT writes issued this cycle
commitStall_o  out  1  blocks ActiveList commit while recovery runs
amtRdAddr0_o..amtRdAddr3_o  out  LOG_W each  AMT read addresses, lane k
amtRdData0_i..amtRdData3_i  in  PHYS_W each  AMT read data, lane k; combinational, same cycle
rmtReady_i  in  1  RMT accepts a write group this cycle
rmtWe0_o..rmtWe3_o  out  1 each  RMT write enable, lane k
rmtPacket0_o..rmtPacket3_o  out  LOG_W+PHYS_W each  {logical index, physical tag}, lane k
recoverBusy_o  out  1  high from the cycle after the request until DONE inclusive
recoverDone_o  out  1  one-cycle pulse when the RMT copy is complete

Behaviour:
- Reset: state IDLE, group counter cnt=0. All outputs are 0 (commitStall_o, recoverBusy_o, recoverDone_o, rmtWe*, rmtPacket*, amtRdAddr*). Reset overrides any in-progress recovery; no partial writes occur after reset.
- States: IDLE, DRAIN, COPY, DONE.
  - IDLE -> DRAIN when recoverReq_i=1; cnt<=0.
  - DRAIN stays while commitInFlight_i=1 (minimum 1 cycle), so AMT writes committed in the request cycle are visible before reads. Exit -> COPY.
  - In COPY, a group fires when rmtReady_i=1: cnt<=cnt+4. If cnt+4 >= NUM_LOG_REGS -> DONE. If rmtReady_i=0, hold cnt and all outputs stable with rmtWe*=0.
  - DONE lasts one cycle: recoverDone_o=1, then -> IDLE.
- commitStall_o and recoverBusy_o are 1 in DRAIN, COPY and DONE; 0 in IDLE.
- Addresses (COPY): amtRdAddrk_o = cnt+k when cnt+k < NUM_LOG_REGS, else 0. Compute with an LOG_W+1 bit sum to avoid wrap. Addresses are 0 outside COPY.
- rmtWek_o = (state==COPY) & rmtReady_i & (cnt+k < NUM_LOG_REGS).
- rmtPacketk_o = {amtRdAddrk_o, amtRdDatak_i} when rmtWek_o, else 0.
- Partial last group: when NUM_LOG_REGS is not a multiple of 4, only the valid lanes write (N=34: last group lanes 0,1).
- recoverReq_i while busy: restart at DRAIN with cnt=0; no recoverDone_o for the aborted pass. A request in the DONE cycle also restarts (DRAIN next, no return to IDLE).
- Latency with rmtReady_i=1 and commitInFlight_i=0: request at cycle t, DRAIN t+1, COPY t+2..t+1+ceil(N/4), DONE t+2+ceil(N/4).

Decomposition:
- Shared package amt_pkg holds:
  - constants NUM_LOG_REGS, LOG_W, PHYS_W, COMMIT_WIDTH=4;
  - recovery state enum {IDLE, DRAIN, COPY, DONE};
  - packet typedef {logical index, physical tag}, shared with ArchMapTable and RMT.
- Single module with no sub-module. The per-lane address/enable generation is a generate loop over COMMIT_WIDTH.

Test Plan:
- Reset then N=34, AMT[i]=i+40, rmtReady=1, pulse recoverReq at cycle 5 -> DRAIN at 6; COPY 7..15 (9 groups); last group rmtWe={0,0,1,1}; DONE pulse at 16; RMT holds i+40 for all 34 entries.
- commitInFlight_i=1 for 3 cycles after request, with AMT[5] written to 99 in the 2nd of them -> DRAIN lasts 3 cycles; lane 1 of group 1 carries {5,99}.
- rmtReady_i toggling 1,0,0,1,... during COPY -> cnt and packets hold while low; rmtWe* is 0 when rmtReady_i=0; total writes stay exactly 34 with no duplicates.
- Second recoverReq_i in COPY at cnt=12 -> DRAIN next cycle, copy restarts at 0; only one recoverDone_o, after the full second pass.
- reset asserted mid-COPY -> next cycle all outputs 0 and state IDLE; a later recoverReq_i performs a full copy.
- NUM_LOG_REGS=32 build -> 8 full groups, no partial group; recoverDone_o 10 cycles after the request.
